sync_fifo_flex: RTL and testbench

Single-clock FIFO, the parametrised successor of the team's async FIFO, for paths where producer and consumer share one clock. Supports arbitrary, non-power-of-2 depth and a true occupancy count. Provides runtime-programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. Sits between same-clock pipeline stages; no pointer synchronisers.

---
 rtl/sync_fifo_flex.sv | 138 +++++++++++++
 tb/tb_sync_fifo_flex.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, a true occupancy count,
// programmable almost-full/almost-empty levels, optional first-word-fall-through
// reads, and sticky overflow/underflow flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 333,
  parameter int FWFT       = 0,
  parameter int CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  W_EN,
  input  logic [DATA_WIDTH-1:0] I_DATA,
  input  logic                  R_EN,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  O_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [CNT_WIDTH-1:0]  COUNT,
  input  logic [CNT_WIDTH-1:0]  AF_LEVEL,
  input  logic [CNT_WIDTH-1:0]  AE_LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  input  logic                  CLR_ERR
);

  localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(MEM_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 wr_acc, rd_acc;

  assign FULL         = (count_q == DEPTH_CNT);
  assign EMPTY        = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= AF_LEVEL);
  assign ALMOST_EMPTY = (count_q <= AE_LEVEL);
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

  // Accesses are judged against registered flags only, so there is no bypass
  // through a full or empty FIFO even when the opposite side is active.
  assign wr_acc = W_EN && !FULL;
  assign rd_acc = R_EN && !EMPTY;

  // Next-state for pointers (explicit wrap at the last entry), occupancy and sticky errors.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    if (rd_acc) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q && !CLR_ERR) || (W_EN && FULL);
    udf_d = (udf_q && !CLR_ERR) || (R_EN && EMPTY);
  end

  // Control state register; contents are discarded on reset by clearing pointers and count.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array is intentionally left unreset; only accepted writes touch it.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wptr_q] <= I_DATA;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic [DATA_WIDTH-1:0] last_q, last_d;

      // Remember the word being popped so O_DATA holds it once the FIFO drains.
      always_comb begin
        last_d = last_q;
        if (rd_acc) last_d = mem[rptr_q];
      end

      // Last-popped register, cleared to zero on reset.
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) last_q <= '0;
        else        last_q <= last_d;
      end

      assign O_DATA  = EMPTY ? last_q : mem[rptr_q];
      assign O_VALID = !EMPTY;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  valid_q, valid_d;

      // Registered read: load the head word on an accepted pop, otherwise hold.
      always_comb begin
        data_d  = data_q;
        valid_d = rd_acc;
        if (rd_acc) data_d = mem[rptr_q];
      end

      // Output data/valid register; valid is a one-cycle pulse per accepted read.
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
        end
      end

      assign O_DATA  = data_q;
      assign O_VALID = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-read instance carries most
// scenarios, a first-word-fall-through instance covers the FWFT read path.
module tb_sync_fifo_flex;

  localparam int DEPTH = 333;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          w_en, r_en, clr_err;
  logic [7:0]    i_data, o_data;
  logic          o_valid, full, empty, afull, aempty, ovf, udf;
  logic [CW-1:0] count, af_level, ae_level;

  logic          f_w_en, f_r_en, f_clr;
  logic [7:0]    f_i_data, f_o_data;
  logic          f_o_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [CW-1:0] f_count;

  int         checks;
  int         failures;
  logic [7:0] q[$];
  logic [7:0] exp;

  sync_fifo_flex #(.DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .FWFT(0)) dut (
    .CLK(clk), .RST_n(rst_n), .W_EN(w_en), .I_DATA(i_data), .R_EN(r_en),
    .O_DATA(o_data), .O_VALID(o_valid), .FULL(full), .EMPTY(empty),
    .ALMOST_FULL(afull), .ALMOST_EMPTY(aempty), .COUNT(count),
    .AF_LEVEL(af_level), .AE_LEVEL(ae_level), .OVERFLOW(ovf),
    .UNDERFLOW(udf), .CLR_ERR(clr_err)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .CLK(clk), .RST_n(rst_n), .W_EN(f_w_en), .I_DATA(f_i_data), .R_EN(f_r_en),
    .O_DATA(f_o_data), .O_VALID(f_o_valid), .FULL(f_full), .EMPTY(f_empty),
    .ALMOST_FULL(f_afull), .ALMOST_EMPTY(f_aempty), .COUNT(f_count),
    .AF_LEVEL(af_level), .AE_LEVEL(ae_level), .OVERFLOW(f_ovf),
    .UNDERFLOW(f_udf), .CLR_ERR(f_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int n, input int mul, input int add);
    for (int i = 0; i < n; i++) begin
      w_en   = 1'b1;
      i_data = 8'(i * mul + add);
      q.push_back(i_data);
      step();
    end
    w_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_en = 0; r_en = 0; clr_err = 0; i_data = 0;
    f_w_en = 0; f_r_en = 0; f_clr = 0; f_i_data = 0;
    af_level = CW'(330); ae_level = CW'(2);
    step(); step();
    checks++; if (count !== CW'(0)) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", o_data); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b%b exp=00", ovf, udf); end
    checks++; if (aempty !== 1'b1 || afull !== 1'b0) begin failures++; $display("[TB] FAIL reset_almost got=ae%b af%b exp=ae1 af0", aempty, afull); end
    checks++; if (f_o_valid !== 1'b0 || f_o_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_fwft got=v%b d%h exp=v0 d00", f_o_valid, f_o_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      w_en = 1'b1; i_data = 8'(i); q.push_back(8'(i));
      step();
      checks++; if (count !== CW'(i + 1)) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=%0d", count, i + 1); end
      checks++; if (afull !== (i + 1 >= 330)) begin failures++; $display("[TB] FAIL fill_afull at=%0d got=%b exp=%b", i + 1, afull, (i + 1 >= 330)); end
      checks++; if (full !== (i + 1 == DEPTH)) begin failures++; $display("[TB] FAIL fill_full at=%0d got=%b exp=%b", i + 1, full, (i + 1 == DEPTH)); end
    end
    i_data = 8'hEE;
    step();
    w_en = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL fill_overflow got=%b exp=1", ovf); end
    checks++; if (count !== CW'(DEPTH)) begin failures++; $display("[TB] FAIL fill_ovf_count got=%0d exp=%0d", count, DEPTH); end
  endtask

  task automatic test_clr_err();
    pulse_clr();
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL clr_overflow got=%b exp=0", ovf); end
    w_en = 1'b1; clr_err = 1'b1; i_data = 8'hDD;
    step();
    w_en = 1'b0; clr_err = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL clr_set_wins got=%b exp=1", ovf); end
    checks++; if (count !== CW'(DEPTH)) begin failures++; $display("[TB] FAIL clr_count got=%0d exp=%0d", count, DEPTH); end
    pulse_clr();
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      r_en = 1'b1;
      step();
      exp = q.pop_front();
      checks++; if (o_valid !== 1'b1 || o_data !== exp) begin failures++; $display("[TB] FAIL drain_data idx=%0d got=v%b d%h exp=v1 d%h", i, o_valid, o_data, exp); end
      checks++; if (count !== CW'(DEPTH - 1 - i)) begin failures++; $display("[TB] FAIL drain_count got=%0d exp=%0d", count, DEPTH - 1 - i); end
      checks++; if (aempty !== (DEPTH - 1 - i <= 2)) begin failures++; $display("[TB] FAIL drain_aempty got=%b exp=%b", aempty, (DEPTH - 1 - i <= 2)); end
    end
    r_en = 1'b0;
    step();
    checks++; if (empty !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_end got=e%b v%b exp=e1 v0", empty, o_valid); end
    checks++; if (o_data !== 8'd76) begin failures++; $display("[TB] FAIL drain_hold got=%h exp=4c", o_data); end
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    checks++; if (udf !== 1'b1) begin failures++; $display("[TB] FAIL underflow got=%b exp=1", udf); end
    checks++; if (o_data !== 8'd76 || o_valid !== 1'b0 || count !== CW'(0)) begin failures++; $display("[TB] FAIL udf_hold got=d%h v%b c%0d exp=d4c v0 c0", o_data, o_valid, count); end
    pulse_clr();
    checks++; if (udf !== 1'b0) begin failures++; $display("[TB] FAIL clr_underflow got=%b exp=0", udf); end
  endtask

  task automatic test_wrap();
    write_burst(200, 7, 3);
    for (int i = 0; i < 200; i++) begin
      r_en = 1'b1; step(); exp = q.pop_front();
      checks++; if (o_data !== exp) begin failures++; $display("[TB] FAIL wrap_drain1 idx=%0d got=%h exp=%h", i, o_data, exp); end
    end
    r_en = 1'b0;
    write_burst(300, 13, 1);
    checks++; if (count !== CW'(300)) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=300", count); end
    for (int i = 0; i < 300; i++) begin
      r_en = 1'b1; step(); exp = q.pop_front();
      checks++; if (o_data !== exp) begin failures++; $display("[TB] FAIL wrap_drain2 idx=%0d got=%h exp=%h", i, o_data, exp); end
    end
    r_en = 1'b0;
    step();
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    write_burst(5, 3, 11);
    for (int k = 0; k < 50; k++) begin
      w_en = 1'b1; r_en = 1'b1; i_data = 8'(100 + k); q.push_back(i_data);
      step();
      exp = q.pop_front();
      checks++; if (count !== CW'(5)) begin failures++; $display("[TB] FAIL b2b_count k=%0d got=%0d exp=5", k, count); end
      checks++; if (o_valid !== 1'b1 || o_data !== exp) begin failures++; $display("[TB] FAIL b2b_data k=%0d got=v%b d%h exp=v1 d%h", k, o_valid, o_data, exp); end
    end
    w_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); exp = q.pop_front();
      checks++; if (o_data !== exp) begin failures++; $display("[TB] FAIL b2b_tail idx=%0d got=%h exp=%h", i, o_data, exp); end
    end
    r_en = 1'b0;
    step();
  endtask

  task automatic test_full_both();
    write_burst(DEPTH, 1, 0);
    w_en = 1'b1; r_en = 1'b1; i_data = 8'hBB;
    step();
    w_en = 1'b0;
    exp = q.pop_front();
    checks++; if (count !== CW'(DEPTH - 1)) begin failures++; $display("[TB] FAIL fullboth_count got=%0d exp=%0d", count, DEPTH - 1); end
    checks++; if (ovf !== 1'b1 || o_data !== exp) begin failures++; $display("[TB] FAIL fullboth_ovf got=o%b d%h exp=o1 d%h", ovf, o_data, exp); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(); exp = q.pop_front();
      checks++; if (o_data !== exp) begin failures++; $display("[TB] FAIL fullboth_drain idx=%0d got=%h exp=%h", i, o_data, exp); end
    end
    r_en = 1'b0;
    step();
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL fullboth_empty got=%b exp=1", empty); end
    pulse_clr();
  endtask

  task automatic test_empty_both();
    w_en = 1'b1; r_en = 1'b1; i_data = 8'h5A;
    step();
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (count !== CW'(1) || udf !== 1'b1) begin failures++; $display("[TB] FAIL emptyboth got=c%0d u%b exp=c1 u1", count, udf); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL emptyboth_valid got=%b exp=0", o_valid); end
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    checks++; if (o_data !== 8'h5A || count !== CW'(0)) begin failures++; $display("[TB] FAIL emptyboth_pop got=d%h c%0d exp=d5a c0", o_data, count); end
    pulse_clr();
  endtask

  task automatic test_thresholds();
    af_level = CW'(0); #1;
    checks++; if (afull !== 1'b1) begin failures++; $display("[TB] FAIL af_zero got=%b exp=1", afull); end
    af_level = CW'(330);
    write_burst(DEPTH, 5, 9);
    af_level = CW'(DEPTH); #1;
    checks++; if (afull !== 1'b1) begin failures++; $display("[TB] FAIL af_depth got=%b exp=1", afull); end
    af_level = CW'(DEPTH + 1); #1;
    checks++; if (afull !== 1'b0) begin failures++; $display("[TB] FAIL af_above got=%b exp=0", afull); end
    ae_level = CW'(DEPTH); #1;
    checks++; if (aempty !== 1'b1) begin failures++; $display("[TB] FAIL ae_depth got=%b exp=1", aempty); end
    ae_level = CW'(DEPTH - 1); #1;
    checks++; if (aempty !== 1'b0) begin failures++; $display("[TB] FAIL ae_below got=%b exp=0", aempty); end
    af_level = CW'(330); ae_level = CW'(2);
  endtask

  task automatic test_reset_midfill();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    q.delete();
    step();
    write_burst(10, 1, 40);
    checks++; if (count !== CW'(10)) begin failures++; $display("[TB] FAIL midfill_count got=%0d exp=10", count); end
    #3; rst_n = 1'b0; #1;
    checks++; if (count !== CW'(0) || empty !== 1'b1) begin failures++; $display("[TB] FAIL async_reset got=c%0d e%b exp=c0 e1", count, empty); end
    #2; rst_n = 1'b1;
    q.delete();
    step();
  endtask

  task automatic test_fwft();
    f_w_en = 1'b1; f_i_data = 8'hA5;
    step();
    f_w_en = 1'b0;
    checks++; if (f_o_valid !== 1'b1 || f_o_data !== 8'hA5) begin failures++; $display("[TB] FAIL fwft_first got=v%b d%h exp=v1 da5", f_o_valid, f_o_data); end
    step();
    checks++; if (f_o_data !== 8'hA5) begin failures++; $display("[TB] FAIL fwft_hold got=%h exp=a5", f_o_data); end
    f_w_en = 1'b1; f_i_data = 8'h3C;
    step();
    f_w_en = 1'b0;
    checks++; if (f_o_data !== 8'hA5 || f_count !== CW'(2)) begin failures++; $display("[TB] FAIL fwft_second got=d%h c%0d exp=da5 c2", f_o_data, f_count); end
    f_r_en = 1'b1;
    step();
    checks++; if (f_o_valid !== 1'b1 || f_o_data !== 8'h3C) begin failures++; $display("[TB] FAIL fwft_pop1 got=v%b d%h exp=v1 d3c", f_o_valid, f_o_data); end
    step();
    f_r_en = 1'b0;
    checks++; if (f_o_valid !== 1'b0 || f_o_data !== 8'h3C) begin failures++; $display("[TB] FAIL fwft_pop2 got=v%b d%h exp=v0 d3c", f_o_valid, f_o_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_clr_err();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_full_both();
    test_empty_both();
    test_thresholds();
    test_reset_midfill();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
